// File: rtl/route_demux4_pkg.sv
// Shared lane constants and sizing helper for the route_demux4 slice.
package route_demux4_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] LANE_A = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_C = 2'd2;
    localparam logic [1:0] LANE_D = 2'd3;

    // Bits needed to count 0..depth entries.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// One consumer lane: small FIFO with a registered head word so the output
// keeps showing the last head after the lane drains.
module demux_lane_fifo
    import route_demux4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic                      valid,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      full
);

    localparam int LW = lvl_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    kept;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign valid     = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign level     = level_q;
    assign head_data = head_q;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & valid;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        kept     = level_q - LW'(pop_ok);
        level_d  = kept + LW'(push_ok);
        head_d   = head_q;
        // Older entries survive the pop: next head comes from RAM; otherwise
        // the incoming word becomes the head directly.
        if (kept != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_ok) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/route_demux4.sv
// 1-to-4 routing demux: steers one producer stream into four independent
// lane FIFOs selected by in_sel.
module route_demux4
    import route_demux4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic [1:0]                          in_sel,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [NUM_LANES*WIDTH-1:0]          out_data,
    output logic [NUM_LANES-1:0]                out_valid,
    input  logic [NUM_LANES-1:0]                out_ready,
    output logic [NUM_LANES*lvl_w(DEPTH)-1:0]   lane_level
);

    localparam int LW = lvl_w(DEPTH);

    logic [NUM_LANES-1:0][WIDTH-1:0] lane_head;
    logic [NUM_LANES-1:0][LW-1:0]    lane_lvl;
    logic [NUM_LANES-1:0]            lane_full;
    logic [NUM_LANES-1:0]            push_vec;

    // Ready looks only at the selected lane's registered fullness.
    assign in_ready = rst_n & ~flush & ~lane_full[in_sel];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign push_vec[k] = in_valid & in_ready & (in_sel == 2'(k));

        demux_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push_vec[k]),
            .push_data (in_data),
            .pop       (out_ready[k]),
            .head_data (lane_head[k]),
            .valid     (out_valid[k]),
            .level     (lane_lvl[k]),
            .full      (lane_full[k])
        );
    end

    assign out_data   = lane_head;
    assign lane_level = lane_lvl;

endmodule

// File: tb/tb_route_demux4.sv
// Randomized and directed bench for route_demux4 against a per-lane queue model.
module tb_route_demux4;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [1:0]        in_sel;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]        out_valid, out_ready;
    logic [4*LW-1:0]   lane_level;

    int n_chk = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] mq [4][$];
    logic [WIDTH-1:0] last_d [4];

    route_demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lane_level (lane_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // One clock: drive inputs, check ready, advance the model, check outputs.
    task automatic step(input bit rst, input bit fl, input bit v, input logic [1:0] sel,
                        input logic [WIDTH-1:0] d, input logic [3:0] ordy);
        bit rdy;
        logic [4*WIDTH-1:0] e_data;
        logic [3:0]         e_vld;
        logic [4*LW-1:0]    e_lvl;
        rst_n = rst; flush = fl; in_valid = v; in_sel = sel; in_data = d; out_ready = ordy;
        #1;
        rdy = rst && !fl && (mq[sel].size() != DEPTH);
        chk("in_ready", {127'd0, in_ready}, {127'd0, rdy});
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin mq[k].delete(); last_d[k] = '0; end
        end else if (fl) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++)
                if (ordy[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            if (v && rdy) mq[sel].push_back(d);
        end
        for (int k = 0; k < 4; k++) begin
            if (mq[k].size() > 0) last_d[k] = mq[k][0];
            e_data[k*WIDTH +: WIDTH] = last_d[k];
            e_vld[k]                 = mq[k].size() > 0;
            e_lvl[k*LW +: LW]        = LW'(mq[k].size());
        end
        #1;
        chk("out_valid",  {124'd0, out_valid}, {124'd0, e_vld});
        chk("lane_level", {120'd0, lane_level}, {120'd0, e_lvl});
        chk("out_data",   out_data, e_data);
    endtask

    task automatic fill_all(input logic [WIDTH-1:0] base);
        for (int i = 0; i < 8; i++)
            step(1, 0, 1, 2'(i % 4), base + WIDTH'(i), 4'b0000);
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        for (int k = 0; k < 4; k++) last_d[k] = '0;

        // Reset held with a valid producer
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd1, 32'hDEAD_BEEF, 4'b1111);
        chk("rst_valid", {124'd0, out_valid}, 128'd0);
        chk("rst_data", out_data, 128'd0);

        // Steering
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 1, 2'(k), 32'h1111_0000 + k, 4'b0000);
            chk("steer_vbit", {127'd0, out_valid[k]}, 128'd1);
        end
        chk("steer_data", out_data, {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000});
        chk("steer_lvl", {120'd0, lane_level}, {120'd0, 8'b01_01_01_01});

        // Backpressure on lane C
        step(1, 1, 0, 2'd0, 0, 4'b0000);
        step(1, 0, 1, 2'd2, 32'hC0, 4'b0000);
        step(1, 0, 1, 2'd2, 32'hC1, 4'b0000);
        step(1, 0, 1, 2'd2, 32'hC2, 4'b0000);
        chk("full_rdy", {127'd0, in_ready}, 128'd0);
        step(1, 0, 1, 2'd0, 32'hA0, 4'b0000);
        chk("stall_other", {127'd0, out_valid[0]}, 128'd1);

        // Full lane with simultaneous pop
        step(1, 0, 1, 2'd2, 32'hC3, 4'b0100);
        chk("fullpop_lvl", {126'd0, lane_level[2*LW +: LW]}, 128'd1);
        step(1, 0, 1, 2'd2, 32'hC3, 4'b0000);
        chk("fullpop_refill", {126'd0, lane_level[2*LW +: LW]}, 128'd2);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 2'd2, 32'hC4 + i, 4'b0100);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd2, 0, 4'b0100);

        // Push+pop at level 1
        step(1, 1, 0, 2'd0, 0, 4'b0000);
        step(1, 0, 1, 2'd1, 32'hA, 4'b0000);
        step(1, 0, 1, 2'd1, 32'hB, 4'b0010);
        chk("pp_lvl", {126'd0, lane_level[LW +: LW]}, 128'd1);
        chk("pp_head", {96'd0, out_data[WIDTH +: WIDTH]}, {96'd0, 32'hB});

        // Flush and reset mid-stream
        fill_all(32'h5000);
        chk("fill_lvl", {120'd0, lane_level}, {120'd0, 8'b10_10_10_10});
        step(1, 1, 1, 2'd3, 32'h77, 4'b0000);
        chk("flush_vld", {124'd0, out_valid}, 128'd0);
        chk("flush_lvl", {120'd0, lane_level}, 128'd0);
        fill_all(32'h6000);
        step(0, 0, 1, 2'd3, 32'h77, 4'b0000);
        chk("rst_mid_data", out_data, 128'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(99) != 0), ($urandom_range(29) == 0),
                 ($urandom_range(9) < 7), 2'($urandom), $urandom, 4'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
